div_sequencer: RTL and testbench



---
 rtl/div_sequencer_pkg.sv | 26 ++
 rtl/div_sequencer_clz32.sv | 14 +
 rtl/div_sequencer.sv | 161 ++++++++++++++++
 tb/tb_div_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the multi-cycle RV32M divide sequencer.
package div_sequencer_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        ITER  = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } div_state_t;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_MIN    = 32'h8000_0000;

    function automatic logic is_signed_op(input div_op_t o);
        return (o == DIV) || (o == REM);
    endfunction

endpackage

// File: rtl/div_sequencer_clz32.sv
// Combinational leading-zero counter; returns 32 for a zero input.
module div_clz32 (
    input  logic [31:0] x,
    output logic [5:0]  cnt
);

    always_comb begin
        cnt = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (x[i]) cnt = 6'(31 - i);
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Radix-2 restoring divider FSM for div/divu/rem/remu with an enabled/completed handshake.
// Define DIV_EARLY_TERM_EN to skip the dividend's leading-zero iterations.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            enabled,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            completed,
    output logic [XLEN-1:0] result
);

    div_state_t       state;
    div_op_t          op_q;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  dvs;
    logic [XLEN-1:0]  rem;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;
    logic             neg_r;
    logic             spec;

    logic             spec_hit;
    logic [XLEN-1:0]  spec_val;
    logic             sgn;
    logic [XLEN-1:0]  abs_a;
    logic [XLEN-1:0]  abs_b;
    logic [XLEN-1:0]  pre_dvd;
    logic [CNT_W-1:0] iter_cnt;
    logic [XLEN:0]    sh;
    logic [XLEN:0]    diff;
    logic [XLEN-1:0]  q_fix;
    logic [XLEN-1:0]  r_fix;

    // Operand combinations whose result is known without iterating.
    always_comb begin
        spec_hit = 1'b1;
        spec_val = '0;
        if (rs2 == '0) begin
            spec_val = op[1] ? rs1 : DIV_ZERO_Q;
        end else if (!op[0] && rs1 == DIV_MIN && rs2 == '1) begin
            spec_val = op[1] ? '0 : DIV_MIN;
        end else if (rs1 == '0) begin
            spec_val = '0;
        end else begin
            spec_hit = 1'b0;
        end
    end

    assign sgn   = is_signed_op(op_q);
    assign abs_a = (sgn && quo[XLEN-1]) ? -quo : quo;
    assign abs_b = (sgn && dvs[XLEN-1]) ? -dvs : dvs;

`ifdef DIV_EARLY_TERM_EN
    logic [5:0] lz;

    div_clz32 u_clz (
        .x   (abs_a),
        .cnt (lz)
    );

    assign pre_dvd  = abs_a << lz;
    assign iter_cnt = CNT_W'(XLEN - 1) - CNT_W'(lz);
`else
    assign pre_dvd  = abs_a;
    assign iter_cnt = CNT_W'(XLEN - 1);
`endif

    // Shifted partial remainder needs XLEN+1 bits before the trial subtract.
    assign sh    = {rem, quo[XLEN-1]};
    assign diff  = sh - {1'b0, dvs};
    assign q_fix = neg_q ? -quo : quo;
    assign r_fix = neg_r ? -rem : rem;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            op_q      <= DIV;
            quo       <= '0;
            dvs       <= '0;
            rem       <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            spec      <= 1'b0;
            busy      <= 1'b0;
            completed <= 1'b0;
            result    <= '0;
        end else begin
            completed <= 1'b0;
            if (flush && state != IDLE && state != DONE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (enabled && !flush) begin
                            op_q <= div_op_t'(op);
                            dvs  <= rs2;
                            busy <= 1'b1;
                            // Special cases skip PREP/ITER and finish after one cycle.
                            if (spec_hit) begin
                                quo   <= spec_val;
                                spec  <= 1'b1;
                                state <= FIXUP;
                            end else begin
                                quo   <= rs1;
                                spec  <= 1'b0;
                                state <= PREP;
                            end
                        end
                    end
                    PREP: begin
                        quo   <= pre_dvd;
                        dvs   <= abs_b;
                        rem   <= '0;
                        neg_q <= sgn && (quo[XLEN-1] ^ dvs[XLEN-1]);
                        neg_r <= sgn && quo[XLEN-1];
                        cnt   <= iter_cnt;
                        state <= ITER;
                    end
                    ITER: begin
                        if (!diff[XLEN]) begin
                            rem <= diff[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], 1'b1};
                        end else begin
                            rem <= sh[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], 1'b0};
                        end
                        if (cnt == '0) state <= FIXUP;
                        else           cnt   <= cnt - 1'b1;
                    end
                    FIXUP: begin
                        if (spec)                       result <= quo;
                        else if (op_q inside {REM, REMU}) result <= r_fix;
                        else                            result <= q_fix;
                        completed <= 1'b1;
                        state     <= DONE;
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed cases, handshake corner cases, random ops.
module tb_div_sequencer;

    logic        clk;
    logic        rstn;
    logic        enabled;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        busy;
    logic        completed;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    div_sequencer dut (
        .clk       (clk),
        .rstn      (rstn),
        .enabled   (enabled),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .busy      (busy),
        .completed (completed),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // RV32M arithmetic straight from the instruction definitions.
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        if (b == 0) return (o == 2'd0 || o == 2'd1) ? 32'hFFFF_FFFF : a;
        if (o == 2'd0 || o == 2'd2) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (o == 2'd0) ? a : 32'd0;
            sa = a;
            sb = b;
            return (o == 2'd0) ? 32'(sa / sb) : 32'(sa % sb);
        end
        return (o == 2'd1) ? a / b : a % b;
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic        sg;
        logic [31:0] mag;
        int          lz;
        sg = (o == 2'd0 || o == 2'd2);
        if (b == 0 || a == 0 || (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`ifdef DIV_EARLY_TERM_EN
        mag = (sg && a[31]) ? -a : a;
        lz = 0;
        while (lz < 32 && mag[31 - lz] == 1'b0) lz++;
        return 2 + 32 - lz;
`else
        mag = a;
        lz  = 0;
        return 34 + lz + int'(mag[0] & 1'b0);
`endif
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res);
        int lat;
        @(negedge clk);
        op = o; rs1 = a; rs2 = b; enabled = 1'b1;
        @(posedge clk);
        #1 enabled = 1'b0;
        check("busy_start", busy, 1);
        lat = 0;
        for (int k = 1; k <= 200 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (completed) lat = k;
        end
        check("latency", lat, ref_lat(o, a, b));
        res = result;
        check("result", result, ref_result(o, a, b));
        @(posedge clk);
        #1;
        check("pulse_len", completed, 0);
        check("busy_end", busy, 0);
    endtask

    task automatic count_pulses(input int cycles, output int pulses, output logic [31:0] first);
        pulses = 0;
        first  = 32'hDEAD_BEEF;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (completed) begin
                if (pulses == 0) first = result;
                pulses++;
            end
        end
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } dir_t;

    dir_t dir_tab[10] = '{
        '{2'd1, 32'd100,        32'd7,          32'd14},
        '{2'd3, 32'd100,        32'd7,          32'd2},
        '{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD},
        '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF},
        '{2'd0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD},
        '{2'd0, 32'd5,          32'd0,          32'hFFFF_FFFF},
        '{2'd3, 32'd5,          32'd0,          32'd5},
        '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000},
        '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0},
        '{2'd1, 32'd0,          32'd9,          32'd0}
    };

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4, 5:    return $urandom_range(0, 1000);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] res;
        logic [31:0] prior;
        logic [31:0] first;
        int          pulses;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        rstn = 1'b0; enabled = 1'b0; op = 2'd0; rs1 = '0; rs2 = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_completed", completed, 0);
        check("rst_result", result, 0);
        rstn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(dir_tab[i].o, dir_tab[i].a, dir_tab[i].b, res);
            check($sformatf("dir%0d", i), res, dir_tab[i].exp);
        end

        // Second start request while busy is dropped.
        @(negedge clk);
        op = 2'd1; rs1 = 32'd100; rs2 = 32'd7; enabled = 1'b1;
        @(posedge clk);
        #1 enabled = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        op = 2'd0; rs1 = 32'd1000; rs2 = 32'd3; enabled = 1'b1;
        @(posedge clk);
        #1 enabled = 1'b0;
        count_pulses(80, pulses, first);
        check("ign_pulses", pulses, 1);
        check("ign_result", first, 32'd14);

        // Flush mid-iteration.
        prior = result;
        @(negedge clk);
        op = 2'd1; rs1 = 32'hFFFF_FFFF; rs2 = 32'd3; enabled = 1'b1;
        @(posedge clk);
        #1 enabled = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_busy", busy, 0);
        count_pulses(50, pulses, first);
        check("flush_pulses", pulses, 0);
        check("flush_result", result, prior);
        run_op(2'd1, 32'd9, 32'd3, res);
        check("after_flush", res, 32'd3);

        // Flush together with a start in IDLE.
        @(negedge clk);
        op = 2'd1; rs1 = 32'd50; rs2 = 32'd5; enabled = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 begin enabled = 1'b0; flush = 1'b0; end
        check("idle_flush_busy", busy, 0);
        count_pulses(40, pulses, first);
        check("idle_flush_pulses", pulses, 0);

        // Reset mid-operation.
        @(negedge clk);
        op = 2'd1; rs1 = 32'hFFFF_FFFF; rs2 = 32'd7; enabled = 1'b1;
        @(posedge clk);
        #1 enabled = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_completed", completed, 0);
        check("midrst_result", result, 0);
        rstn = 1'b1;
        count_pulses(50, pulses, first);
        check("midrst_pulses", pulses, 0);
        run_op(2'd3, 32'd1234, 32'd100, res);
        check("after_rst", res, 32'd34);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick_operand();
            rb = pick_operand();
            run_op(ro, ra, rb, res);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
